// File: rtl/pl_exc_if_stage.sv
// Instruction-fetch stage: PC register, next-PC selection with exception/eret redirect,
// and the IF/ID pipeline register carrying the fetched word and its tags.
module pl_exc_if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] EXC_BASE = 32'h0000_0008,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic [1:0]       pcsrc,
    input  logic [31:0]      bpc,
    input  logic [31:0]      rpc,
    input  logic [31:0]      jpc,
    input  logic             id_is_jb,
    input  logic             exc_req,
    input  logic             eret_req,
    input  logic [31:0]      epc,
    output logic [31:0]      i_addr,
    input  logic [31:0]      i_data,
    output logic [31:0]      d_inst,
    output logic [31:0]      d_pc,
    output logic [31:0]      d_pc4,
    output logic             d_valid,
    output logic             d_bd,
    output logic [CNT_W-1:0] fetch_cnt
);

    localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

    logic [31:0] pc_r;
    logic [31:0] pc4_s;
    logic [31:0] target_s;

    // Every PC source is forced onto a word boundary.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & WORD_MASK;
    endfunction

    assign pc4_s  = pc_r + 32'd4;
    assign i_addr = pc_r;

    // Normal next-PC selection driven by decode.
    always_comb begin
        target_s = pc4_s;
        case (pcsrc)
            2'b00:   target_s = pc4_s;
            2'b01:   target_s = bpc;
            2'b10:   target_s = rpc;
            2'b11:   target_s = jpc;
            default: target_s = pc4_s;
        endcase
    end

    // PC and IF/ID register update: rst > exc_req > eret_req > stall > advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r      <= align_word(RESET_PC);
            d_inst    <= 32'h0000_0000;
            d_pc      <= 32'h0000_0000;
            d_pc4     <= 32'h0000_0000;
            d_valid   <= 1'b0;
            d_bd      <= 1'b0;
            fetch_cnt <= {CNT_W{1'b0}};
        end else if (exc_req) begin
            // Squash keeps d_pc/d_pc4 so CP0 still sees the last fetched address.
            pc_r    <= align_word(EXC_BASE);
            d_inst  <= 32'h0000_0000;
            d_valid <= 1'b0;
            d_bd    <= 1'b0;
        end else if (eret_req) begin
            pc_r    <= align_word(epc);
            d_inst  <= 32'h0000_0000;
            d_valid <= 1'b0;
            d_bd    <= 1'b0;
        end else if (!stall) begin
            pc_r      <= align_word(target_s);
            d_inst    <= i_data;
            d_pc      <= pc_r;
            d_pc4     <= pc4_s;
            d_valid   <= 1'b1;
            d_bd      <= id_is_jb;
            fetch_cnt <= fetch_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            pc_r <= pc_r;
        end
    end

endmodule

// File: tb/tb_pl_exc_if_stage.sv
// Bench for pl_exc_if_stage: directed scenarios then random traffic, every cycle compared
// against an architectural model of the fetch stage and a hashed instruction memory.
module tb_pl_exc_if_stage;

    logic        clk = 1'b0;
    logic        rst, stall, id_is_jb, exc_req, eret_req;
    logic [1:0]  pcsrc;
    logic [31:0] bpc, rpc, jpc, epc;
    logic [31:0] i_addr, i_data, d_inst, d_pc, d_pc4, fetch_cnt;
    logic        d_valid, d_bd;

    int checks   = 0;
    int failures = 0;

    // Reference state
    logic [31:0] m_pc, m_inst, m_dpc, m_dpc4, m_cnt;
    logic        m_valid, m_bd;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    assign i_data = mem_word(i_addr);

    pl_exc_if_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .pcsrc(pcsrc), .bpc(bpc), .rpc(rpc), .jpc(jpc),
        .id_is_jb(id_is_jb), .exc_req(exc_req), .eret_req(eret_req), .epc(epc),
        .i_addr(i_addr), .i_data(i_data), .d_inst(d_inst), .d_pc(d_pc), .d_pc4(d_pc4),
        .d_valid(d_valid), .d_bd(d_bd), .fetch_cnt(fetch_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock using the current inputs, clock the DUT, compare.
    task automatic cycle();
        logic [31:0] tg [4];
        tg[0] = m_pc + 32'd4;
        tg[1] = bpc;
        tg[2] = rpc;
        tg[3] = jpc;
        if (rst) begin
            m_pc = 32'd0; m_inst = 32'd0; m_dpc = 32'd0; m_dpc4 = 32'd0;
            m_valid = 1'b0; m_bd = 1'b0; m_cnt = 32'd0;
        end else if (exc_req || eret_req) begin
            m_pc    = exc_req ? 32'h8 : {epc[31:2], 2'b00};
            m_inst  = 32'd0;
            m_valid = 1'b0;
            m_bd    = 1'b0;
        end else if (!stall) begin
            m_inst  = mem_word(m_pc);
            m_dpc   = m_pc;
            m_dpc4  = m_pc + 32'd4;
            m_valid = 1'b1;
            m_bd    = id_is_jb;
            m_cnt   = m_cnt + 32'd1;
            m_pc    = tg[pcsrc] / 32'd4 * 32'd4;
        end
        @(posedge clk);
        #1;
        chk("i_addr", i_addr, m_pc);
        chk("d_inst", d_inst, m_inst);
        chk("d_pc", d_pc, m_dpc);
        chk("d_pc4", d_pc4, m_dpc4);
        chk("d_valid", {31'd0, d_valid}, {31'd0, m_valid});
        chk("d_bd", {31'd0, d_bd}, {31'd0, m_bd});
        chk("fetch_cnt", fetch_cnt, m_cnt);
    endtask

    task automatic drive(input logic r, input logic st, input logic [1:0] ps,
                         input logic [31:0] tgt, input logic jb, input logic ex,
                         input logic er, input logic [31:0] ep);
        rst = r; stall = st; pcsrc = ps; bpc = tgt; rpc = tgt; jpc = tgt;
        id_is_jb = jb; exc_req = ex; eret_req = er; epc = ep;
        cycle();
    endtask

    initial begin
        // Reset held three cycles
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 2'b00, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
        // Sequential fetch
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 2'b00, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
        // Jump from PC 0 with delay-slot tag
        drive(1'b1, 1'b0, 2'b00, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
        drive(1'b0, 1'b0, 2'b11, 32'h74, 1'b1, 1'b0, 1'b0, 32'd0);
        drive(1'b0, 1'b0, 2'b00, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
        // Branch/jr targets, then stall at 0x98
        drive(1'b0, 1'b0, 2'b01, 32'h90, 1'b1, 1'b0, 1'b0, 32'd0);
        drive(1'b0, 1'b0, 2'b10, 32'h98, 1'b1, 1'b0, 1'b0, 32'd0);
        drive(1'b0, 1'b1, 2'b11, 32'h400, 1'b1, 1'b0, 1'b0, 32'd0);
        drive(1'b0, 1'b1, 2'b01, 32'h500, 1'b0, 1'b0, 1'b0, 32'd0);
        drive(1'b0, 1'b0, 2'b00, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
        // Stall plus exception at 0xB8
        drive(1'b0, 1'b0, 2'b11, 32'hB8, 1'b0, 1'b0, 1'b0, 32'd0);
        drive(1'b0, 1'b1, 2'b00, 32'd0, 1'b0, 1'b1, 1'b0, 32'd0);
        drive(1'b0, 1'b0, 2'b00, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
        // eret with unaligned epc, then normal
        drive(1'b0, 1'b0, 2'b00, 32'd0, 1'b0, 1'b0, 1'b1, 32'h8B);
        drive(1'b0, 1'b0, 2'b00, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
        // Both redirects: exception wins; then reset during stall
        drive(1'b0, 1'b0, 2'b11, 32'h300, 1'b0, 1'b1, 1'b1, 32'h200);
        drive(1'b0, 1'b0, 2'b00, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
        drive(1'b0, 1'b1, 2'b00, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
        drive(1'b1, 1'b1, 2'b11, 32'h300, 1'b1, 1'b1, 1'b1, 32'h200);
        // PC+4 wrap at the top of the address space, unaligned jump target
        drive(1'b0, 1'b0, 2'b00, 32'd0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF);
        drive(1'b0, 1'b0, 2'b00, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
        drive(1'b0, 1'b0, 2'b11, 32'h1237, 1'b0, 1'b0, 1'b0, 32'd0);
        drive(1'b0, 1'b0, 2'b00, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
        // Random traffic
        for (int i = 0; i < 400; i++) begin
            rst      = ($urandom_range(0, 49) == 0);
            stall    = ($urandom_range(0, 3) == 0);
            exc_req  = ($urandom_range(0, 15) == 0);
            eret_req = ($urandom_range(0, 15) == 0);
            pcsrc    = 2'($urandom_range(0, 3));
            bpc      = $urandom;
            rpc      = $urandom;
            jpc      = $urandom;
            epc      = $urandom;
            id_is_jb = 1'($urandom_range(0, 1));
            cycle();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
